// File: rtl/fifo_burst_reader_if.sv
// Bundles the FIFO read-side port and the downstream valid/ready stream
// of the burst reader. master = the reader, slave = FIFO plus sink.
interface fifo_burst_reader_if #(
    parameter int DATA_W  = 64,
    parameter int USEDW_W = 8
);
    logic [DATA_W-1:0]  fifo_q;
    logic               fifo_rdempty;
    logic [USEDW_W-1:0] fifo_rdusedw;
    logic               fifo_rdreq;

    logic [DATA_W-1:0]  m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_sop;
    logic               m_eop;

    modport master (
        input  fifo_q, fifo_rdempty, fifo_rdusedw, m_ready,
        output fifo_rdreq, m_data, m_valid, m_sop, m_eop
    );

    modport slave (
        output fifo_q, fifo_rdempty, fifo_rdusedw, m_ready,
        input  fifo_rdreq, m_data, m_valid, m_sop, m_eop
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the ADC sample dual-clock FIFO.
// Drains one burst (full or timed-out partial) into a 3-entry buffer and
// presents it as a valid/ready stream with start/end-of-burst markers.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a full burst or idle timeout on a partial fill
// S_BURST | issuing fifo_rdreq until words_left reaches 0
// S_WAIT  | all reads issued; draining buffer until the eop word is taken
module fifo_burst_reader #(
    parameter int DATA_W    = 64,
    parameter int USEDW_W   = 8,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    fifo_burst_reader_if.master       bus,
    output logic                      o_burst_done,
    output logic [15:0]               o_burst_count
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int EW = DATA_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_WAIT} state_t;

    state_t             r_state, w_state_nxt;
    logic [USEDW_W-1:0] r_words_left, w_words_left_nxt;
    logic [TW-1:0]      r_idle_timer, w_idle_timer_nxt;
    logic               r_first, w_first_nxt;

    logic [EW-1:0]      r_buf [0:2];
    logic [1:0]         r_buf_cnt;
    logic               r_inflight, r_inflight_sop, r_inflight_eop;

    logic               w_rdreq, w_pop, w_done;
    logic [2:0]         w_occ;
    logic [1:0]         w_wr_idx;

    // Buffer head and occupancy; occupancy counts the word still in the FIFO read pipe.
    assign w_pop    = (r_buf_cnt != 2'd0) && bus.m_ready;
    assign w_occ    = {1'b0, r_buf_cnt} + {2'b00, r_inflight};
    assign w_wr_idx = r_buf_cnt - {1'b0, w_pop};

    assign bus.fifo_rdreq = w_rdreq;
    assign bus.m_valid    = (r_buf_cnt != 2'd0);
    assign bus.m_data     = r_buf[0][DATA_W-1:0];
    assign bus.m_sop      = r_buf[0][EW-1];
    assign bus.m_eop      = r_buf[0][EW-2];
    assign o_burst_done   = w_done;

    // Next-state, read issue and burst completion.
    always_comb begin
        w_state_nxt      = r_state;
        w_words_left_nxt = r_words_left;
        w_idle_timer_nxt = '0;
        w_first_nxt      = r_first;
        w_rdreq          = 1'b0;
        w_done           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable && (bus.fifo_rdusedw >= USEDW_W'(BURST_LEN))) begin
                    w_state_nxt      = S_BURST;
                    w_words_left_nxt = USEDW_W'(BURST_LEN);
                    w_first_nxt      = 1'b1;
                end else if (i_enable && !bus.fifo_rdempty &&
                             (r_idle_timer == TW'(TIMEOUT - 1))) begin
                    // A zero word count here means the flags disagree; just restart the timer.
                    if (bus.fifo_rdusedw != '0) begin
                        w_state_nxt      = S_BURST;
                        w_words_left_nxt = bus.fifo_rdusedw;
                        w_first_nxt      = 1'b1;
                    end
                end else if (i_enable && !bus.fifo_rdempty) begin
                    w_idle_timer_nxt = r_idle_timer + TW'(1);
                end
            end
            S_BURST: begin
                w_rdreq = !bus.fifo_rdempty && (r_words_left != '0) && (w_occ < 3'd3);
                if (w_rdreq) begin
                    w_words_left_nxt = r_words_left - USEDW_W'(1);
                    w_first_nxt      = 1'b0;
                    if (r_words_left == USEDW_W'(1))
                        w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_pop && r_buf[0][EW-2]) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_reset) begin
            w_rdreq = 1'b0;
            w_done  = 1'b0;
        end
    end

    // State register, words_left, idle timer and first-word flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_words_left <= '0;
            r_idle_timer <= '0;
            r_first      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_words_left <= w_words_left_nxt;
            r_idle_timer <= w_idle_timer_nxt;
            r_first      <= w_first_nxt;
        end
    end

    // Read pipe tracking and 3-entry shift buffer (head at index 0).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 3; i++) r_buf[i] <= '0;
            r_buf_cnt      <= 2'd0;
            r_inflight     <= 1'b0;
            r_inflight_sop <= 1'b0;
            r_inflight_eop <= 1'b0;
        end else begin
            if (w_pop) begin
                r_buf[0] <= r_buf[1];
                r_buf[1] <= r_buf[2];
            end
            if (r_inflight)
                r_buf[w_wr_idx] <= {r_inflight_sop, r_inflight_eop, bus.fifo_q};
            r_buf_cnt      <= r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
            r_inflight     <= w_rdreq;
            r_inflight_sop <= w_rdreq && r_first;
            r_inflight_eop <= w_rdreq && (r_words_left == USEDW_W'(1));
        end
    end

    // Completed-burst counter, wraps naturally at 16 bits.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            o_burst_count <= 16'd0;
        else if (w_done)
            o_burst_count <= o_burst_count + 16'd1;
    end
endmodule
